// File: rtl/fpmul_arb_pkg.sv
// Shared types and defaults for the FPmul arbiter slice.
package fpmul_arb_pkg;

    localparam int unsigned DEF_LAT   = 4;
    localparam int unsigned DEF_DEPTH = 4;
    localparam int unsigned TAG_ID_W  = 8;

    typedef logic [31:0] fp32_t;

    // Tag carried alongside each multiply through the FPmul pipeline.
    typedef struct packed {
        logic                valid;
        logic [TAG_ID_W-1:0] id;
    } tag_t;

endpackage

// File: rtl/fpmul_arb_fifo.sv
// Per-requester response FIFO: ring buffer with occupancy count, push and pop
// allowed on the same edge even when full.
module fpmul_arb_fifo
    import fpmul_arb_pkg::*;
#(
    parameter int unsigned DEPTH = DEF_DEPTH,
    parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  fp32_t         push_data,
    input  logic          pop,
    output fp32_t         pop_data,
    output logic [CW-1:0] count
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fp32_t         mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    assign pop_data = mem[rd_ptr];

    // Storage write; a push into a full FIFO lands in the slot being popped.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fpmul_arbiter.sv
// Round-robin arbiter sharing one pipelined FPmul between N_REQ requesters,
// with credit-based per-requester response FIFOs.
module fpmul_arbiter
    import fpmul_arb_pkg::*;
#(
    parameter int unsigned N_REQ = 2,
    parameter int unsigned LAT   = DEF_LAT,
    parameter int unsigned DEPTH = DEF_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [N_REQ-1:0][31:0] req_a,
    input  logic [N_REQ-1:0][31:0] req_b,
    output logic [N_REQ-1:0]       rsp_valid,
    output logic [N_REQ-1:0][31:0] rsp_data,
    input  logic [N_REQ-1:0]       rsp_ready,
    output fp32_t                  mul_a,
    output fp32_t                  mul_b,
    input  fp32_t                  mul_z
);

    localparam int unsigned IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned CW  = $clog2(DEPTH + 1);
    localparam int unsigned SW  = CW + 1;

    logic [N_REQ-1:0] elig;
    logic [N_REQ-1:0] push;
    logic [N_REQ-1:0] pop;
    logic             grant_vld;
    logic [IDW-1:0]   grant_idx;
    logic [IDW-1:0]   rr;
    logic             issue;
    int unsigned      scan;
    tag_t             tags [LAT];
    tag_t             tag_out;

    assign issue   = grant_vld & rst_n;
    assign tag_out = tags[LAT-1];

    // Round-robin search for the first eligible requester at or above rr.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        scan      = 0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            scan = (32'(rr) + k) % N_REQ;
            if (!grant_vld && elig[scan[IDW-1:0]]) begin
                grant_vld = 1'b1;
                grant_idx = scan[IDW-1:0];
            end
        end
    end

    // Only the granted requester sees ready; held low throughout reset.
    always_comb begin
        req_ready = '0;
        if (issue) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    // Pointer, FPmul operand registers and the tag pipeline that mirrors FPmul.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr    <= '0;
            mul_a <= '0;
            mul_b <= '0;
            for (int unsigned j = 0; j < LAT; j++) begin
                tags[j] <= '0;
            end
        end else begin
            if (issue) begin
                rr    <= (grant_idx == IDW'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
                mul_a <= req_a[grant_idx];
                mul_b <= req_b[grant_idx];
            end
            tags[0].valid <= issue;
            tags[0].id    <= TAG_ID_W'(grant_idx);
            for (int unsigned j = 1; j < LAT; j++) begin
                tags[j] <= tags[j-1];
            end
        end
    end

    for (genvar g = 0; g < N_REQ; g++) begin : g_req
        logic [CW-1:0] inflight;
        logic [CW-1:0] cnt;
        logic          inc;
        logic          dec;

        assign inc       = issue && (grant_idx == IDW'(g));
        assign dec       = push[g];
        assign push[g]   = tag_out.valid && (tag_out.id == TAG_ID_W'(g));
        assign pop[g]    = rsp_valid[g] && rsp_ready[g];
        assign rsp_valid[g] = (cnt != '0);
        // Credits cover both results still in FPmul and results parked in the
        // FIFO, so a push on exit can never overflow.
        assign elig[g]   = req_valid[g] && ((SW'(inflight) + SW'(cnt)) < SW'(DEPTH));

        // Count of this requester's multiplies still inside FPmul.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                inflight <= '0;
            end else begin
                case ({inc, dec})
                    2'b10:   inflight <= inflight + 1'b1;
                    2'b01:   inflight <= inflight - 1'b1;
                    default: inflight <= inflight;
                endcase
            end
        end

        fpmul_arb_fifo #(
            .DEPTH (DEPTH),
            .CW    (CW)
        ) u_fifo (
            .clk       (clk),
            .rst_n     (rst_n),
            .push      (push[g]),
            .push_data (mul_z),
            .pop       (pop[g]),
            .pop_data  (rsp_data[g]),
            .count     (cnt)
        );
    end

endmodule

// File: tb/tb_fpmul_arbiter.sv
// Directed bench for fpmul_arbiter with a behavioural LAT-cycle FPmul stand-in.
module tb_fpmul_arbiter;
    import fpmul_arb_pkg::*;

    localparam int unsigned LAT   = 4;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned NV    = 10;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] z;
    } op_t;

    typedef struct {
        int unsigned req;
        op_t         op;
    } vec_t;

    logic             clk;
    logic             rst_n;
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [1:0][31:0] req_a;
    logic [1:0][31:0] req_b;
    logic [1:0]       rsp_valid;
    logic [1:0][31:0] rsp_data;
    logic [1:0]       rsp_ready;
    logic [31:0]      mul_a;
    logic [31:0]      mul_b;
    logic [31:0]      mul_z;

    fpmul_arbiter #(
        .N_REQ (2),
        .LAT   (LAT),
        .DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_ready (rsp_ready),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .mul_z     (mul_z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Truncating fp32 multiply for normal operands and zeros.
    function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
        logic        s;
        logic [47:0] p;
        logic [22:0] m;
        int          e;
        s = a[31] ^ b[31];
        if (a[30:0] == 31'd0 || b[30:0] == 31'd0) return {s, 31'd0};
        p = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
        e = int'(a[30:23]) + int'(b[30:23]) - 127;
        if (p[47]) begin
            m = p[46:24];
            e = e + 1;
        end else begin
            m = p[45:23];
        end
        return {s, e[7:0], m};
    endfunction

    // FPmul stand-in: product of the registered operands appears LAT edges later.
    logic [31:0] pipe [LAT-1];
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < LAT - 1; k++) pipe[k] <= '0;
        end else begin
            pipe[0] <= fp_mul(mul_a, mul_b);
            for (int k = 1; k < LAT - 1; k++) pipe[k] <= pipe[k-1];
        end
    end
    assign mul_z = pipe[LAT-2];

    vec_t        vtab [NV];
    op_t         src  [2][$];
    logic [31:0] expq [2][$];
    logic [1:0]  fire;
    logic [1:0]  rdy_ctl;
    logic [1:0]  last_nz_fire;
    logic [1:0]  first_grant;
    bit          any_fired;
    int          cyc, checks, errors;
    int          issues [2];
    int          pops [2];
    int          rsp_seen [2];
    int          first_fire [2];
    int          last_fire [2];
    int          bubbles, gap, multi, repeats;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic clear_stats();
        for (int i = 0; i < 2; i++) begin
            issues[i] = 0; pops[i] = 0; rsp_seen[i] = 0;
            first_fire[i] = -1; last_fire[i] = -1;
        end
        bubbles = 0; gap = 0; multi = 0; repeats = 0;
        any_fired = 0; last_nz_fire = '0; first_grant = '0;
    endtask

    // One clock: drive at negedge, sample settled values 2 time units later.
    task automatic cycle();
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            if (fire[i]) void'(src[i].pop_front());
            if (src[i].size() != 0) begin
                req_valid[i] = 1'b1;
                req_a[i]     = src[i][0].a;
                req_b[i]     = src[i][0].b;
            end else begin
                req_valid[i] = 1'b0;
            end
        end
        rsp_ready = rdy_ctl;
        #2;
        fire = req_valid & req_ready;
        for (int i = 0; i < 2; i++) begin
            if (fire[i]) begin
                expq[i].push_back(src[i][0].z);
                issues[i]++;
                if (first_fire[i] < 0) first_fire[i] = cyc;
                last_fire[i] = cyc;
            end
            if (rsp_valid[i]) rsp_seen[i]++;
            if (rsp_valid[i] && rsp_ready[i]) begin
                pops[i]++;
                if (expq[i].size() == 0) begin
                    check($sformatf("unexpected_rsp%0d", i), rsp_data[i], 32'hxxxxxxxx);
                end else begin
                    check($sformatf("rsp_data%0d", i), rsp_data[i], expq[i].pop_front());
                end
            end
        end
        if (fire != 2'b00) begin
            if (fire == 2'b11) multi++;
            if (any_fired && fire == last_nz_fire) repeats++;
            if (!any_fired) first_grant = fire;
            bubbles += gap;
            gap = 0;
            any_fired = 1;
            last_nz_fire = fire;
        end else if (any_fired) begin
            gap++;
        end
        cyc++;
    endtask

    task automatic drain(input int maxc, input string name);
        int n;
        n = 0;
        while ((src[0].size() + src[1].size() + expq[0].size() + expq[1].size()) != 0 && n < maxc) begin
            cycle();
            n++;
        end
        check(name, 32'(src[0].size() + src[1].size() + expq[0].size() + expq[1].size()), 32'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        int lat_fire, lat_rsp, n;

        vtab[0] = '{req: 0, op: '{a: 32'h40000000, b: 32'h40400000, z: 32'h40C00000}};
        vtab[1] = '{req: 1, op: '{a: 32'h3F800000, b: 32'h3F800000, z: 32'h3F800000}};
        vtab[2] = '{req: 1, op: '{a: 32'h40000000, b: 32'h3F800000, z: 32'h40000000}};
        vtab[3] = '{req: 1, op: '{a: 32'h40400000, b: 32'h3F800000, z: 32'h40400000}};
        vtab[4] = '{req: 0, op: '{a: 32'hC0000000, b: 32'h40800000, z: 32'hC1000000}};
        vtab[5] = '{req: 0, op: '{a: 32'h3F000000, b: 32'h40800000, z: 32'h40000000}};
        vtab[6] = '{req: 1, op: '{a: 32'h3FC00000, b: 32'h3FC00000, z: 32'h40100000}};
        vtab[7] = '{req: 0, op: '{a: 32'h00000000, b: 32'h40400000, z: 32'h00000000}};
        vtab[8] = '{req: 1, op: '{a: 32'h40A00000, b: 32'h40A00000, z: 32'h41C80000}};
        vtab[9] = '{req: 0, op: '{a: 32'h41200000, b: 32'hBF800000, z: 32'hC1200000}};

        checks = 0; errors = 0; cyc = 0; fire = '0; rdy_ctl = 2'b11;
        clear_stats();

        // Reset state with both requesters asking.
        rst_n = 1'b0; req_valid = 2'b11; rsp_ready = 2'b11;
        req_a = {32'h40000000, 32'h40400000}; req_b = {32'h3F800000, 32'h3F800000};
        repeat (2) @(negedge clk);
        #2;
        check("reset_req_ready", 32'(req_ready), 32'd0);
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_mul_a", mul_a, 32'd0);
        check("reset_mul_b", mul_b, 32'd0);
        @(negedge clk);
        rst_n = 1'b1; req_valid = 2'b00;

        // Single op: 2.0 * 3.0 on requester 0, latency from issue to rsp_valid.
        clear_stats();
        src[0].push_back(vtab[0].op);
        lat_fire = -1; lat_rsp = -1; n = 0;
        while (lat_rsp < 0 && n < 20) begin
            cycle();
            if (fire[0] && lat_fire < 0) lat_fire = cyc;
            if (rsp_valid[0] && lat_rsp < 0) lat_rsp = cyc;
            n++;
        end
        // Issue is sampled just before its edge; rsp_valid just after edge+LAT.
        check("single_latency", 32'(lat_rsp - lat_fire), 32'(LAT + 1));
        drain(20, "single_drain");
        check("single_mul_a_hold", mul_a, 32'h40000000);
        check("single_mul_b_hold", mul_b, 32'h40400000);

        // Requester 1 back-to-back: x1.0 of 1.0, 2.0, 3.0.
        clear_stats();
        for (int k = 1; k <= 3; k++) src[1].push_back(vtab[k].op);
        drain(40, "b2b_drain");
        check("b2b_issues", 32'(issues[1]), 32'd3);
        check("b2b_span", 32'(last_fire[1] - first_fire[1]), 32'd2);

        // Both streaming with full rsp_ready: strict alternation, no bubbles.
        clear_stats();
        for (int k = 0; k < 8; k++) begin
            src[0].push_back(vtab[k].op);
            src[1].push_back(vtab[NV-1-k].op);
        end
        drain(100, "alt_drain");
        check("alt_issues0", 32'(issues[0]), 32'd8);
        check("alt_issues1", 32'(issues[1]), 32'd8);
        check("alt_bubbles", 32'(bubbles), 32'd0);
        check("alt_multi", 32'(multi), 32'd0);
        check("alt_repeats", 32'(repeats), 32'd0);
        check("alt_first_grant", 32'(first_grant), 32'd1);

        // Table vectors routed to their own requesters.
        clear_stats();
        for (int k = 0; k < NV; k++) src[vtab[k].req].push_back(vtab[k].op);
        drain(100, "table_drain");
        check("table_pops0", 32'(pops[0]), 32'd5);
        check("table_pops1", 32'(pops[1]), 32'd5);

        // Backpressure on requester 0 must not stall requester 1.
        clear_stats();
        rdy_ctl = 2'b10;
        for (int k = 0; k < 6; k++) src[0].push_back(vtab[k].op);
        for (int k = 0; k < 12; k++) src[1].push_back(vtab[(k + 3) % NV].op);
        repeat (40) cycle();
        check("bp_issues0", 32'(issues[0]), 32'd4);
        check("bp_issues1", 32'(issues[1]), 32'd12);
        check("bp_ready0", 32'(req_ready[0]), 32'd0);
        check("bp_rsp_valid0", 32'(rsp_valid[0]), 32'd1);
        check("bp_pops0", 32'(pops[0]), 32'd0);
        check("bp_head0", rsp_data[0], vtab[0].op.z);
        rdy_ctl = 2'b11;
        drain(80, "bp_drain");
        check("bp_total0", 32'(pops[0]), 32'd6);

        // Reset two cycles after an issue discards the pending result.
        clear_stats();
        src[0].push_back(vtab[4].op);
        n = 0;
        while (!fire[0] && n < 10) begin
            cycle();
            n++;
        end
        check("midrst_issue", 32'(fire[0]), 32'd1);
        cycle();
        cycle();
        @(negedge clk);
        rst_n = 1'b0; req_valid = 2'b11;
        for (int i = 0; i < 2; i++) begin
            src[i].delete();
            expq[i].delete();
        end
        fire = '0;
        #2;
        check("midrst_req_ready", 32'(req_ready), 32'd0);
        check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("midrst_mul_a", mul_a, 32'd0);
        check("midrst_mul_b", mul_b, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1; req_valid = 2'b00;
        clear_stats();
        repeat (12) cycle();
        check("midrst_no_rsp", 32'(rsp_seen[0] + rsp_seen[1]), 32'd0);

        // Pointer restarts at requester 0 after reset.
        clear_stats();
        src[0].push_back(vtab[5].op);
        src[1].push_back(vtab[6].op);
        drain(40, "postrst_drain");
        check("postrst_first_grant", 32'(first_grant), 32'd1);
        check("postrst_pops", 32'(pops[0] + pops[1]), 32'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fpmul_arbiter.md
FPMUL_ARBITER -- requirements
Module: fpmul_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 2: number of requesters sharing one FPmul instance.
REQ-002 SHALL have parameter LAT, default 4: FPmul latency in cycles, counted from the edge at which mul_a/mul_b take new operands to the edge at which the product is valid on mul_z.
REQ-003 SHALL have parameter DEPTH, default 4: number of entries in each per-requester response FIFO.
REQ-004 clk  in  1  single clock; all flops sample on its rising edge.
REQ-005 rst_n  in  1  reset, asynchronous and active-low.
REQ-006 req_valid  in  N_REQ  per-requester operand valid.
REQ-007 req_ready  out  N_REQ  per-requester operand accept.
REQ-008 req_a, req_b  in  N_REQ x 32  IEEE-754 single-precision operands.
REQ-009 rsp_valid  out  N_REQ  per-requester result valid.
REQ-010 rsp_data  out  N_REQ x 32  product bits.
REQ-011 rsp_ready  in  N_REQ  per-requester result accept.
REQ-012 mul_a, mul_b  out  32  registered operands to FPmul.
REQ-013 mul_z  in  32  FPmul product.

Function
REQ-014 An operand transfer for requester i SHALL occur on an edge where req_valid[i] and req_ready[i] are both 1 ("issue").
REQ-015 At most one issue SHALL occur per cycle, across all requesters.
REQ-016 Requester i SHALL be eligible iff req_valid[i] is 1 and inflight[i] + count[i] < DEPTH, where count[i] is the occupancy of FIFO i.
REQ-017 Grant SHALL be round-robin over eligible requesters, searching upward from pointer rr.
REQ-018 After an issue by requester i, rr SHALL become (i+1) mod N_REQ; rr SHALL be unchanged when no issue occurs.
REQ-019 req_ready[i] SHALL be 1 only for the granted requester and SHALL be combinational from req_valid and the credit state.
REQ-020 On an issue, mul_a/mul_b SHALL load req_a/req_b of the granted requester at that edge; otherwise they SHALL hold their value.
REQ-021 A LAT-stage tag shift register of {valid, id} SHALL enter {1, i} on an issue and {0, x} otherwise.
REQ-022 When the tag exits with valid = 1, mul_z SHALL be pushed into FIFO[id] at that edge (issue edge + LAT), making rsp_valid visible LAT cycles after the issue.
REQ-023 inflight[i] SHALL increment on an issue by i and decrement on a tag exit for i; simultaneous increment and decrement SHALL leave it unchanged.
REQ-024 FIFO push and pop SHALL be legal on the same edge, including when the FIFO is full, because the credit rule of REQ-016 guarantees no overflow.
REQ-025 rsp_valid[i] SHALL equal (count[i] != 0), and rsp_data[i] SHALL be the head of FIFO i.
REQ-026 A pop SHALL occur on rsp_valid[i] & rsp_ready[i].
REQ-027 Results SHALL be returned to each requester in that requester's issue order.
REQ-028 One requester's backpressure SHALL NOT stall issues for any other requester.
REQ-029 Back-to-back issues at one per cycle SHALL be sustained, with no bubbles, while credits are available.

Reset
REQ-030 While rst_n = 0, the block SHALL hold: all FIFOs empty, all tag valids 0, inflight = 0, rr = 0, and mul_a = mul_b = 0.
REQ-031 While rst_n = 0, req_ready and rsp_valid SHALL be 0.
REQ-032 Reset asserted mid-operation SHALL discard all in-flight and buffered results, with no rsp_valid after deassertion for pre-reset issues.
REQ-033 FPmul SHALL be reset from the same rst_n.

Structure
REQ-034 The shared package fpmul_arb_pkg SHALL hold: the default LAT/DEPTH constants, the fp32_t 32-bit typedef, and the tag struct {valid, id}.
REQ-035 One sub-module, fpmul_arb_fifo (parameter DEPTH, 32-bit, push/pop/count), SHALL be instantiated once per requester.

Verification
REQ-036 Single op: req 0 issues A=0x40000000, B=0x40400000 -> rsp_valid[0] exactly 4 cycles later with rsp_data[0]=0x40C00000.
REQ-037 Both requesters continuously valid with rsp_ready all 1 -> grants alternate 0,1,0,1; one issue per cycle; every result routed to its own requester.
REQ-038 rsp_ready[0]=0 while req 0 streams -> req_ready[0] drops after 4 issues; req 1 keeps issuing every cycle; after rsp_ready[0]=1, four results drain in order.
REQ-039 Req 1 sends 1.0, 2.0, 3.0 times 0x3F800000 back-to-back -> outputs 0x3F800000, 0x40000000, 0x40400000 in order.
REQ-040 Assert rst_n low 2 cycles after an issue -> outputs at reset values; no rsp_valid afterwards until a new issue is made.
